// File: rtl/wb_capture_reader_pkg.sv
// Shared types and address helpers for the capture-memory reader.
package wb_capture_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    OUT,
    DONE
  } state_t;

  localparam int unsigned c_mem_base    = 32'h80;
  localparam logic [3:0]  c_wb_sel      = 4'hF;
  localparam int unsigned c_word_stride = 2;

  // Word address of an entry half: high word at base + 2*idx, low word one above.
  function automatic logic [31:0] entry_word_adr(input logic [31:0] base,
                                                 input logic [31:0] idx,
                                                 input logic        lo);
    return base + idx * 32'(c_word_stride) + {31'b0, lo};
  endfunction

endpackage

// File: rtl/wb_capture_reader_txn.sv
// Single Wishbone pipelined read transaction engine.
// Optional ack timeout: WB_CAPTURE_READER_TIMEOUT_EN.
module wb_capture_reader_txn
  import wb_capture_reader_pkg::*;
#(
  parameter int unsigned g_adr_width = 8,
  parameter int unsigned g_timeout   = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   req_i,
  input  logic [g_adr_width-1:0] adr_i,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic [g_adr_width-1:0] wb_adr_o,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  input  logic                   wb_rty_i,
  input  logic                   wb_stall_i,
  input  logic [31:0]            wb_dat_i,
  output logic                   rdy_o,
  output logic                   err_o,
  output logic [31:0]            dat_o
);

  logic term;
  logic tmo;

  assign term  = wb_ack_i | wb_err_i | wb_rty_i;
  assign rdy_o = wb_cyc_o & wb_ack_i;
  assign err_o = (wb_cyc_o & (wb_err_i | wb_rty_i)) | tmo;
  assign dat_o = wb_dat_i;

`ifdef WB_CAPTURE_READER_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  assign tmo = wb_cyc_o & ~term & (tmo_cnt == g_timeout - 1);

  // Cycles spent waiting on the current transaction.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || req_i) begin
      tmo_cnt <= '0;
    end else if (wb_cyc_o) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  logic unused_tmo;
  assign tmo        = 1'b0;
  assign unused_tmo = (g_timeout != 0);
`endif

  // Bus cycle control: stb leaves once accepted, cyc leaves once terminated.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_adr_o <= '0;
    end else if (req_i) begin
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      wb_adr_o <= adr_i;
    end else begin
      if (wb_stb_o && !wb_stall_i) begin
        wb_stb_o <= 1'b0;
      end
      if (wb_cyc_o && (term || tmo)) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_capture_reader.sv
// Drains 64-bit capture entries as hi/lo Wishbone word pairs onto a valid/ready stream.
// Optional ack timeout: WB_CAPTURE_READER_TIMEOUT_EN.
module wb_capture_reader
  import wb_capture_reader_pkg::*;
#(
  parameter int unsigned g_adr_width  = 8,
  parameter int unsigned g_mem_base   = c_mem_base,
  parameter int unsigned g_depth_log2 = 6,
  parameter int unsigned g_timeout    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [g_depth_log2-1:0] first_i,
  input  logic [g_depth_log2:0]   count_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [3:0]              wb_sel_o,
  output logic [g_adr_width-1:0]  wb_adr_o,
  output logic [31:0]             wb_dat_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  input  logic                    wb_stall_i,
  input  logic [31:0]             wb_dat_i,
  output logic [63:0]             data_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam logic [g_depth_log2:0] c_one = {{g_depth_log2{1'b0}}, 1'b1};

  state_t                   state;
  logic [g_depth_log2-1:0]  idx;
  logic [g_depth_log2-1:0]  idx_nxt;
  logic [g_depth_log2:0]    remaining;
  logic [31:0]              hi_q;
  logic                     abort_pend;
  logic                     lo_issued;

  logic                     txn_req;
  logic [g_adr_width-1:0]   txn_adr;
  logic                     txn_rdy;
  logic                     txn_err;
  logic [31:0]              txn_dat;

  assign wb_we_o  = 1'b0;
  assign wb_sel_o = c_wb_sel;
  assign wb_dat_o = '0;
  assign idx_nxt  = idx + {{(g_depth_log2-1){1'b0}}, 1'b1};

  // Transaction launch: combinational so cyc rises on the edge that decides to read.
  // The low word launches one cycle after the high ack so cyc can drop in between.
  always_comb begin
    txn_req = 1'b0;
    txn_adr = '0;
    case (state)
      IDLE: if (start_i && count_i != '0) begin
        txn_req = 1'b1;
        txn_adr = g_adr_width'(entry_word_adr(g_mem_base, 32'(first_i), 1'b0));
      end
      RD_LO: if (!lo_issued && !abort_i) begin
        txn_req = 1'b1;
        txn_adr = g_adr_width'(entry_word_adr(g_mem_base, 32'(idx), 1'b1));
      end
      OUT: if (valid_o && ready_i && !abort_i && remaining != c_one) begin
        txn_req = 1'b1;
        txn_adr = g_adr_width'(entry_word_adr(g_mem_base, 32'(idx_nxt), 1'b0));
      end
      default: ;
    endcase
  end

  wb_capture_reader_txn #(
    .g_adr_width (g_adr_width),
    .g_timeout   (g_timeout)
  ) u_txn (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req_i      (txn_req),
    .adr_i      (txn_adr),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_adr_o   (wb_adr_o),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_rty_i   (wb_rty_i),
    .wb_stall_i (wb_stall_i),
    .wb_dat_i   (wb_dat_i),
    .rdy_o      (txn_rdy),
    .err_o      (txn_err),
    .dat_o      (txn_dat)
  );

  // Run sequencing with registered status and stream outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      idx        <= '0;
      remaining  <= '0;
      hi_q       <= '0;
      abort_pend <= 1'b0;
      lo_issued  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          error_o    <= 1'b0;
          abort_pend <= 1'b0;
          if (count_i == '0) begin
            done_o <= 1'b1;
          end else begin
            idx       <= first_i;
            remaining <= count_i;
            busy_o    <= 1'b1;
            state     <= RD_HI;
          end
        end
        RD_HI: begin
          if (abort_i) abort_pend <= 1'b1;
          if (txn_err) begin
            error_o <= 1'b1;
            done_o  <= 1'b1;
            state   <= DONE;
          end else if (txn_rdy) begin
            hi_q <= txn_dat;
            if (abort_pend || abort_i) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              lo_issued <= 1'b0;
              state     <= RD_LO;
            end
          end
        end
        RD_LO: begin
          if (txn_req) lo_issued <= 1'b1;
          if (!lo_issued && abort_i) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            if (abort_i) abort_pend <= 1'b1;
            if (txn_err) begin
              error_o <= 1'b1;
              done_o  <= 1'b1;
              state   <= DONE;
            end else if (txn_rdy) begin
              if (abort_pend || abort_i) begin
                done_o <= 1'b1;
                state  <= DONE;
              end else begin
                data_o  <= {hi_q, txn_dat};
                valid_o <= 1'b1;
                state   <= OUT;
              end
            end
          end
        end
        OUT: begin
          if (abort_i) begin
            valid_o <= 1'b0;
            done_o  <= 1'b1;
            state   <= DONE;
          end else if (ready_i) begin
            valid_o   <= 1'b0;
            idx       <= idx_nxt;
            remaining <= remaining - c_one;
            if (remaining == c_one) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              state <= RD_HI;
            end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_capture_reader.md
# wb_capture_reader

Wishbone pipelined initiator that drains a 64-bit capture memory exposed by a Cheby-generated responder as pairs of 32-bit words. After a start pulse it reads a programmable run of entries, high word first. It assembles each pair into one 64-bit word and presents it on a valid/ready stream. It sits between the capture register bank and a local consumer, such as a DMA packer or a checksum engine, replacing software polling.

## Interface
Parameters:
- g_adr_width, 8, width of the word address (wb_adr_o covers byte bits [g_adr_width+1:2])
- g_mem_base, 8'h80, word address of entry 0 high word (byte 0x200)
- g_depth_log2, 6, log2 of the number of 64-bit entries (64)
- g_timeout, 255, ack timeout in cycles (only with the timeout macro)

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; synchronous, active-low
- start_i  in  1  single-cycle start pulse, ignored unless idle
- abort_i  in  1  request to stop after the current bus cycle
- first_i  in  g_depth_log2  first entry index, sampled on start
- count_i  in  g_depth_log2+1  number of entries to read, sampled on start
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at end of run
- error_o  out  1  sticky error flag; cleared on next accepted start
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe
- wb_we_o  out  1  constant 0
- wb_sel_o  out  4  constant 4'hF
- wb_adr_o  out  g_adr_width  word address
- wb_dat_o  out  32  constant 0
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1  responder handshake
- wb_dat_i  in  32  read data
- data_o  out  64  assembled entry {hi, lo}
- valid_o  out  1  data_o valid
- ready_i  in  1  consumer accepts data_o

## Operation
- FSM states:
  - IDLE: start_i latches first/count, clears error_o, and moves to RD_HI. If count=0, pulse done_o and stay in IDLE.
  - RD_HI: read word at g_mem_base + 2*idx. On ack, store it as bits [63:32] and go to RD_LO.
  - RD_LO: read word at g_mem_base + 2*idx + 1. On ack, store it as bits [31:0], set valid_o and go to OUT.
  - OUT: hold data_o until valid_o & ready_i. Then increment idx modulo 2^g_depth_log2 and decrement remaining. Go to RD_HI if remaining ≠ 0, else DONE.
  - DONE: one cycle; pulse done_o, return to IDLE.
- Bus cycle rules:
  - cyc and stb rise together.
  - stb drops the cycle after it is sampled with wb_stall_i=0.
  - cyc drops in the cycle after ack, err or rty.
  - At most one transaction is outstanding at any time.
- wb_err_i or wb_rty_i: set error_o, discard the partial entry (no valid_o), go to DONE.
- Abort:
  - abort_i in RD_HI/RD_LO completes the outstanding cycle, discards the entry, then goes to DONE.
  - abort_i in OUT drops valid_o immediately and goes to DONE.
  - abort_i in IDLE has no effect.
- Entry index wraps: first=62, count=4 reads entries 62, 63, 0, 1.
- start_i while busy is ignored.

## Timing
- Reset values: wb_cyc_o=0, wb_stb_o=0, busy_o=0, done_o=0, error_o=0, valid_o=0, data_o=0, wb_adr_o=0.
- Reset mid-run abandons the bus cycle immediately (cyc=0 next edge); any late ack is ignored.
- start_i at edge N gives busy_o=1 and cyc/stb=1 at edge N+1.
- No fixed ack latency is assumed; each word costs 2 cycles plus the responder latency.
- Next RD_HI cyc rises the cycle after the output handshake.
- An ack in the same cycle as the stall release is legal and ends the transaction.
- busy_o is high from the cycle after start through DONE inclusive.

## Configuration
- Macro: WB_CAPTURE_READER_TIMEOUT_EN.
- Defined: a counter runs while cyc is high and restarts on each new transaction. Reaching g_timeout cycles without ack/err/rty drops cyc, sets error_o and goes to DONE.
- Undefined: no counter; the reader waits indefinitely for the responder.

## Structure
- Shared package:
  - FSM state enum (IDLE, RD_HI, RD_LO, OUT, DONE)
  - memory base and entry-to-word address helper
  - constants for sel=4'hF and word stride 2
- One natural sub-module: wb_capture_reader_txn. It owns cyc/stb/stall/ack/err/rty handling and the optional timeout, returning rdy/err/data to the FSM.

## Test plan
- Basic run, responder with 3-cycle ack:
  - first=0, count=2, memory entry0=64'h0123_4567_89AB_CDEF, entry1=64'hFEDC_BA98_7654_3210.
  - Expect addresses 0x80, 0x81, 0x82, 0x83, two beats with those values, then done_o.
- Wrap: first=63, count=2 -> addresses 0xFE, 0xFF, 0x80, 0x81; done_o after the second beat.
- Backpressure: ready_i low for 10 cycles on beat 0 -> data_o stable, no bus activity until the handshake.
- Stall: wb_stall_i high for 4 cycles -> stb held 5 cycles then drops, cyc held until ack.
- Error: wb_err_i on RD_LO of entry 1, count=3 -> one beat only, error_o=1, done_o pulse; next start clears error_o.
- Timeout (macro defined, g_timeout=16), responder never acks -> cyc drops after 16 cycles, error_o=1. Then assert rst_n_i=0 mid-run in a separate test -> all outputs at reset values next edge.
